// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, master ids, word size.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_DMA = 1'b1;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant: a lone requester wins outright,
// and on a tie the master that did not win last time is chosen.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_grant_valid,
    output logic o_grant_id
);

    always_comb begin
        o_grant_valid = i_valid0 | i_valid1;
        o_grant_id    = MASTER_CPU;
        if (i_valid0 && i_valid1) begin
            o_grant_id = ~i_last_grant;
        end else if (i_valid1) begin
            o_grant_id = MASTER_DMA;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter and single-access sequencer in front of the word-wide,
// big-endian data memory. One access in flight; response held until taken.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 32'h0800,
    parameter int unsigned ADDR_W   = 32
)
(
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_write,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [31:0]       m0_req_wdata,
    output logic              m0_rsp_valid,
    input  logic              m0_rsp_ready,
    output logic [31:0]       m0_rsp_rdata,
    output logic              m0_rsp_err,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_write,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [31:0]       m1_req_wdata,
    output logic              m1_rsp_valid,
    input  logic              m1_rsp_ready,
    output logic [31:0]       m1_rsp_rdata,
    output logic              m1_rsp_err,

    output logic              mem_write,
    output logic              mem_read,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(MEM_SIZE - WORD_BYTES);

    state_t       r_state;
    logic         r_last_grant;
    logic         r_owner;
    logic         r_write;
    logic         r_m0_rsp_valid;
    logic         r_m1_rsp_valid;
    logic [31:0]  r_rdata;
    logic         r_err;
    logic         r_mem_write;
    logic         r_mem_read;
    logic [31:0]  r_mem_address;
    logic [31:0]  r_mem_write_data;

    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_accept;
    logic              w_req_write;
    logic [ADDR_W-1:0] w_req_addr;
    logic [31:0]       w_req_wdata;
    logic              w_req_err;
    logic              w_rsp_taken;

    rr_arbiter2 u_rr (
        .i_valid0      (m0_req_valid),
        .i_valid1      (m1_req_valid),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    assign w_accept     = (r_state == ST_IDLE) && w_grant_valid;
    assign m0_req_ready = w_accept && (w_grant_id == MASTER_CPU);
    assign m1_req_ready = w_accept && (w_grant_id == MASTER_DMA);

    assign w_req_write = (w_grant_id == MASTER_DMA) ? m1_req_write : m0_req_write;
    assign w_req_addr  = (w_grant_id == MASTER_DMA) ? m1_req_addr  : m0_req_addr;
    assign w_req_wdata = (w_grant_id == MASTER_DMA) ? m1_req_wdata : m0_req_wdata;

    // Full-width compare so wrapped or high addresses never alias into the array.
    assign w_req_err = (w_req_addr[1:0] != 2'b00) || (w_req_addr > LAST_WORD_ADDR);

    assign w_rsp_taken = (r_m0_rsp_valid && m0_rsp_ready) || (r_m1_rsp_valid && m1_rsp_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_last_grant     <= MASTER_DMA;
            r_owner          <= MASTER_CPU;
            r_write          <= 1'b0;
            r_m0_rsp_valid   <= 1'b0;
            r_m1_rsp_valid   <= 1'b0;
            r_rdata          <= '0;
            r_err            <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last_grant     <= w_grant_id;
                        r_owner          <= w_grant_id;
                        r_write          <= w_req_write;
                        r_mem_address    <= 32'(w_req_addr);
                        r_mem_write_data <= w_req_wdata;
                        if (w_req_err) begin
                            r_err          <= 1'b1;
                            r_rdata        <= '0;
                            r_m0_rsp_valid <= (w_grant_id == MASTER_CPU);
                            r_m1_rsp_valid <= (w_grant_id == MASTER_DMA);
                            r_state        <= ST_RESP;
                        end else begin
                            r_err       <= 1'b0;
                            r_mem_write <= w_req_write;
                            r_mem_read  <= ~w_req_write;
                            r_state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_rdata        <= r_write ? 32'h0 : mem_read_data;
                    r_mem_write    <= 1'b0;
                    r_mem_read     <= 1'b0;
                    r_m0_rsp_valid <= (r_owner == MASTER_CPU);
                    r_m1_rsp_valid <= (r_owner == MASTER_DMA);
                    r_state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_taken) begin
                        r_m0_rsp_valid <= 1'b0;
                        r_m1_rsp_valid <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_mem_write    <= 1'b0;
                    r_mem_read     <= 1'b0;
                    r_m0_rsp_valid <= 1'b0;
                    r_m1_rsp_valid <= 1'b0;
                    r_state        <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_rsp_valid   = r_m0_rsp_valid;
    assign m1_rsp_valid   = r_m1_rsp_valid;
    assign m0_rsp_rdata   = r_rdata;
    assign m1_rsp_rdata   = r_rdata;
    assign m0_rsp_err     = r_err;
    assign m1_rsp_err     = r_err;
    assign mem_write      = r_mem_write;
    assign mem_read       = r_mem_read;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural big-endian byte memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_req_write;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic        m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [31:0] m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_write;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic        m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [31:0] m1_rsp_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_address, mem_write_data;
    logic [31:0] mem_read_data = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(.MEM_SIZE(32'h0800), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_write(m0_req_write),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(m0_rsp_valid),
        .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_write(m1_req_write),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(m1_rsp_valid),
        .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Byte memory: writes on the falling edge, read data sampled on the strobe's rising edge.
    logic [7:0] mem [0:2047];
    always @(negedge clk) begin
        if (mem_write) begin
            mem[{mem_address[10:2], 2'd0}] = mem_write_data[31:24];
            mem[{mem_address[10:2], 2'd1}] = mem_write_data[23:16];
            mem[{mem_address[10:2], 2'd2}] = mem_write_data[15:8];
            mem[{mem_address[10:2], 2'd3}] = mem_write_data[7:0];
        end
    end
    always @(posedge mem_read) begin
        #1;
        mem_read_data = {mem[{mem_address[10:2], 2'd0}], mem[{mem_address[10:2], 2'd1}],
                         mem[{mem_address[10:2], 2'd2}], mem[{mem_address[10:2], 2'd3}]};
    end

    int          rd_cycles, wr_cycles;
    logic [31:0] strobe_addr;
    always @(negedge clk) begin
        if (mem_read)  rd_cycles++;
        if (mem_write) wr_cycles++;
        if (mem_read || mem_write) strobe_addr = mem_address;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem[{a[10:2], 2'd0}], mem[{a[10:2], 2'd1}], mem[{a[10:2], 2'd2}], mem[{a[10:2], 2'd3}]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_txn(input bit m, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err, output int lat);
        bit ok;
        rd = 32'hX; err = 1'bx; lat = 0;
        rd_cycles = 0; wr_cycles = 0; strobe_addr = 32'hFFFF_FFFF;
        if (m) begin m1_req_valid = 1; m1_req_write = wr; m1_req_addr = addr; m1_req_wdata = wd; end
        else   begin m0_req_valid = 1; m0_req_write = wr; m0_req_addr = addr; m0_req_wdata = wd; end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((m ? m1_req_ready : m0_req_ready) === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 32'(ok), 32'd1);
            m0_req_valid = 0; m1_req_valid = 0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        m0_req_valid = 0; m1_req_valid = 0;
        ok = 0;
        for (int i = 1; i <= 20; i++) begin
            if ((m ? m1_rsp_valid : m0_rsp_valid) === 1'b1) begin ok = 1; lat = i; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("rsp_timeout", 32'(ok), 32'd1);
            return;
        end
        check("other_rsp_valid", 32'(m ? m0_rsp_valid : m1_rsp_valid), 32'd0);
        rd  = m ? m1_rsp_rdata : m0_rsp_rdata;
        err = m ? m1_rsp_err   : m0_rsp_err;
        if (m) m1_rsp_ready = 1; else m0_rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        m0_rsp_ready = 0; m1_rsp_ready = 0;
        check("rsp_valid_cleared", 32'(m ? m1_rsp_valid : m0_rsp_valid), 32'd0);
    endtask

    typedef struct {
        bit          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          rds;
        int          wrs;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [9];
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          g_id  [8];
        int          g_cyc [8];
        int          n_g;
        logic [31:0] held;

        vecs[0] = '{0, 0, 32'h0000_0010, 32'h0,         0, 32'h1122_3344, 2, 1, 0};
        vecs[1] = '{1, 1, 32'h0000_07FC, 32'hDEAD_BEEF, 0, 32'h0,         2, 0, 1};
        vecs[2] = '{1, 0, 32'h0000_07FC, 32'h0,         0, 32'hDEAD_BEEF, 2, 1, 0};
        vecs[3] = '{0, 0, 32'h0000_0013, 32'h0,         1, 32'h0,         1, 0, 0};
        vecs[4] = '{1, 1, 32'h0000_0800, 32'h1234_5678, 1, 32'h0,         1, 0, 0};
        vecs[5] = '{0, 0, 32'h0000_0000, 32'h0,         0, 32'hA0B1_C2D3, 2, 1, 0};
        vecs[6] = '{0, 0, 32'hFFFF_FFFC, 32'h0,         1, 32'h0,         1, 0, 0};
        vecs[7] = '{1, 1, 32'h0000_07FE, 32'h5555_AAAA, 1, 32'h0,         1, 0, 0};
        vecs[8] = '{0, 0, 32'h0000_07F8, 32'h0,         0, 32'h0102_0304, 2, 1, 0};

        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        {mem[16], mem[17], mem[18], mem[19]} = 32'h1122_3344;
        {mem[20], mem[21], mem[22], mem[23]} = 32'h5566_7788;
        {mem[0], mem[1], mem[2], mem[3]}     = 32'hA0B1_C2D3;
        {mem[2040], mem[2041], mem[2042], mem[2043]} = 32'h0102_0304;

        rst = 1;
        m0_req_valid = 0; m0_req_write = 0; m0_req_addr = 0; m0_req_wdata = 0; m0_rsp_ready = 0;
        m1_req_valid = 0; m1_req_write = 0; m1_req_addr = 0; m1_req_wdata = 0; m1_rsp_ready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("rst_outputs", {m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err,
                              mem_write, mem_read, m0_req_ready, m1_req_ready}, 32'd0);
        check("rst_rdata", m0_rsp_rdata, 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);

        // Contention straight out of reset: master 0 wins first, then strict alternation.
        @(negedge clk);
        m0_req_valid = 1; m0_req_write = 0; m0_req_addr = 32'h10;
        m1_req_valid = 1; m1_req_write = 0; m1_req_addr = 32'h14;
        m0_rsp_ready = 1; m1_rsp_ready = 1;
        n_g = 0;
        for (int i = 0; i < 13; i++) begin
            #1;
            if (m0_req_ready && m1_req_ready) check("cont_both_ready", 32'd1, 32'd0);
            if ((m0_req_ready || m1_req_ready) && n_g < 8) begin
                g_id[n_g]  = m1_req_ready ? 1 : 0;
                g_cyc[n_g] = i;
                n_g++;
            end
            if (m0_rsp_valid) check("cont_m0_rdata", m0_rsp_rdata, 32'h1122_3344);
            if (m1_rsp_valid) check("cont_m1_rdata", m1_rsp_rdata, 32'h5566_7788);
            if (m0_rsp_valid && m1_rsp_valid) check("cont_both_rsp", 32'd1, 32'd0);
            @(negedge clk);
        end
        m0_req_valid = 0; m1_req_valid = 0;
        repeat (4) @(negedge clk);
        m0_rsp_ready = 0; m1_rsp_ready = 0;
        check("cont_grant_count", 32'(n_g), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < n_g) begin
                check($sformatf("cont_grant_id%0d", k), 32'(g_id[k]), 32'(k % 2));
                check($sformatf("cont_grant_cyc%0d", k), 32'(g_cyc[k]), 32'(3 * k));
            end
        end

        foreach (vecs[i]) begin
            run_txn(vecs[i].m, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, err, lat);
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_read_cycles", i), 32'(rd_cycles), 32'(vecs[i].rds));
            check($sformatf("v%0d_write_cycles", i), 32'(wr_cycles), 32'(vecs[i].wrs));
            check($sformatf("v%0d_strobe_addr", i), strobe_addr,
                  vecs[i].err ? 32'hFFFF_FFFF : vecs[i].addr);
        end
        check("mem_bytes_7fc", mem_word(32'h7FC), 32'hDEAD_BEEF);
        check("mem_bytes_7fe", {mem[2046], mem[2047]}, 32'h0000_BEEF);

        // Backpressure: m0 response held for 5 cycles while m1 waits.
        m0_req_valid = 1; m0_req_write = 0; m0_req_addr = 32'h10;
        #1;
        check("bp_m0_ready", 32'(m0_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        m0_req_valid = 0;
        m1_req_valid = 1; m1_req_write = 0; m1_req_addr = 32'h14;
        for (int i = 0; i < 10 && !m0_rsp_valid; i++) begin
            #1;
            check("bp_m1_ready_wait", 32'(m1_req_ready), 32'd0);
            @(negedge clk);
        end
        check("bp_rsp_valid", 32'(m0_rsp_valid), 32'd1);
        held = m0_rsp_rdata;
        check("bp_rdata", held, 32'h1122_3344);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_m1_ready_held", 32'(m1_req_ready), 32'd0);
            check("bp_rsp_held", {m0_rsp_valid, m1_rsp_valid, m0_rsp_err}, 32'b100);
            check("bp_rdata_held", m0_rsp_rdata, held);
            @(negedge clk);
        end
        m0_rsp_ready = 1;
        #1;
        check("bp_m1_ready_at_hs", 32'(m1_req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        m0_rsp_ready = 0;
        #1;
        check("bp_m1_ready_after", 32'(m1_req_ready), 32'd1);
        check("bp_m0_rsp_cleared", 32'(m0_rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        m1_req_valid = 0; m1_rsp_ready = 1;
        repeat (3) @(negedge clk);
        m1_rsp_ready = 0;

        // Reset while a store to 0x20 is in ACCESS: the write stands, the response is dropped.
        m0_req_valid = 1; m0_req_write = 1; m0_req_addr = 32'h20; m0_req_wdata = 32'hCAFE_F00D;
        #1;
        check("rst_store_ready", 32'(m0_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        m0_req_valid = 0;
        rst = 1;
        #1;
        check("rst_store_strobe", 32'(mem_write), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check("rst_store_mem", mem_word(32'h20), 32'hCAFE_F00D);
        check("rst_store_outputs", {m0_rsp_valid, m1_rsp_valid, mem_write, mem_read}, 32'd0);
        @(negedge clk);
        #1;
        check("rst_store_no_rsp", {m0_rsp_valid, m1_rsp_valid}, 32'd0);
        m0_req_valid = 1; m0_req_write = 0; m0_req_addr = 32'h10;
        m1_req_valid = 1; m1_req_write = 0; m1_req_addr = 32'h14;
        #1;
        check("rst_tie_winner", {m0_req_ready, m1_req_ready}, 32'b10);
        m0_req_valid = 0; m1_req_valid = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and access sequencer in front of the word-wide, big-endian data memory.
- Master 0 is the CPU load/store unit; master 1 is a DMA or debug loader.
- Each request is accepted with a valid/ready handshake and checked for alignment and range.
- Accepted requests become a single one-cycle memory access; the response is held until the owning master takes it. Only one access is in flight at a time.

Parameters:
- MEM_SIZE, 32'h0800, memory size in bytes; must match the memory instance.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- m0_req_valid  in  1  master 0 request present
- m0_req_ready  out  1  master 0 request accepted this cycle
- m0_req_write  in  1  1 = store, 0 = load
- m0_req_addr  in  ADDR_W  byte address
- m0_req_wdata  in  32  store data
- m0_rsp_valid  out  1  master 0 response present
- m0_rsp_ready  in  1  master 0 takes response
- m0_rsp_rdata  out  32  load data; 0 for stores and errors
- m0_rsp_err  out  1  misaligned or out-of-range access
- m1_*  same nine ports as m0_*, for master 1
- mem_write  out  1  memory write strobe; memory writes on the falling clk edge
- mem_read  out  1  memory read strobe; memory samples on the rising edge of this strobe
- mem_address  out  32  memory byte address
- mem_write_data  out  32  memory write data
- mem_read_data  in  32  memory read data

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (rst=1 at a rising edge):
  - state=IDLE, last_grant=1 (master 0 wins the first tie).
  - All rsp_valid, rsp_err, mem_write and mem_read = 0; rsp_rdata = 0; mem_address and mem_write_data = 0.
- IDLE, grant rule:
  - mk_req_ready = 1 only in IDLE, and only for the winner. The winner is derived combinationally from the two valids and last_grant.
  - Single requester wins outright.
  - If both request, the master not equal to last_grant wins (round-robin).
  - ready never depends on rsp_ready.
- IDLE, acceptance (valid && ready at a rising edge):
  - Latch write, addr, wdata and the master id; set last_grant = id.
  - Error condition: addr[1:0] != 0, or addr > MEM_SIZE-4 (unsigned, full ADDR_W compare).
  - Error: go to RESP with err=1, rdata=0. The memory is never strobed.
  - Otherwise: go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_write = write; mem_read = !write. Both are registered (set on entry), so they are glitch-free.
  - mem_address and mem_write_data are stable for the whole cycle.
  - At the edge leaving ACCESS: capture rdata = mem_read_data for loads, or 0 for stores. Clear both strobes, then go to RESP.
  - Strobes must be low in every cycle outside ACCESS, so mem_read produces one rising edge per load.
- RESP:
  - Only the owning master's rsp_valid is 1; rdata and err are held stable.
  - On rsp_valid && rsp_ready at an edge: clear rsp_valid and go to IDLE.
  - A new grant is first possible in the following cycle; there is no bypass.
- Latency from the acceptance edge N:
  - Valid access: rsp_valid high from edge N+2.
  - Error: rsp_valid high from edge N+1.
- Throughput: at most one access every 3 cycles (valid) or every 2 cycles (error), assuming rsp_ready is held high.
- Starvation: with both masters continuously valid, grants alternate 0,1,0,1,...
- The non-granted master's request inputs are ignored. It must hold them, and it sees ready=0.
- Reset mid-operation:
  - Reset sampled at the end of ACCESS: that cycle's memory write (falling edge) has already completed and stands. The response is discarded and the block returns to IDLE.
  - Reset in RESP: the response is dropped.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2.
  - MASTER_CPU=1'b0, MASTER_DMA=1'b1.
  - WORD_BYTES=4.
- One natural sub-module, rr_arbiter2: a combinational two-way round-robin grant from the two valids and last_grant. The FSM, the error check and the response registers stay in dmem_arbiter.

Test Plan:
- Single load: memory preloaded with bytes 0x11,0x22,0x33,0x44 at 0x10; m0 load at 0x10 -> mem_read high for exactly one cycle, m0_rsp_valid at N+2, rdata=0x11223344, err=0.
- Store then load: m1 store 0xDEADBEEF at 0x7FC, then m1 load at 0x7FC -> mem_write high for one cycle at address 0x7FC; load returns 0xDEADBEEF; bytes at 0x7FC..0x7FF are DE,AD,BE,EF.
- Contention: both masters continuously valid with loads; rsp_ready tied 1 -> grant order 0,1,0,1; a new grant every 3 cycles; each response goes only to its owner.
- Errors: m0 load at 0x13, m1 store at 0x800 -> err=1, rdata=0 at N+1; mem_write and mem_read stay 0 throughout.
- Backpressure: m0 load with rsp_ready low for 5 cycles while m1 is valid -> rsp held stable; m1_req_ready stays 0 until the cycle after the m0 handshake.
- Reset: rst asserted during ACCESS of a store to 0x20 -> memory holds the new word; no rsp_valid; state=IDLE. The next tie is won by master 0.
